alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
- REQ-001: Parameter WIDTH, default 64, operand and result width in bits (legal 8..64).
- REQ-002: Port clk input 1, sole clock; all state updates on the rising edge.
- REQ-003: Port reset_n input 1, asynchronous, active-low reset.
- REQ-004: Port in_valid input 1, operation request valid.
- REQ-005: Port in_ready output 1, block can accept a request.
- REQ-006: Port opcode input 4: NOTHING=0, ADD=1, SUB=2, MUL=3, DIV=4, XOR=5, AND=6, OR=7, REM=8, NOT=9; 10-15 illegal.
- REQ-007: Port is_signed input 1, two's-complement interpretation for DIV/REM.
- REQ-008: Port value1 input WIDTH, first operand (dividend for DIV/REM).
- REQ-009: Port value2 input WIDTH, second operand (divisor for DIV/REM).
- REQ-010: Port out_valid output 1, result available.
- REQ-011: Port out_ready input 1, consumer accepts result.
- REQ-012: Port result output WIDTH, registered result.
- REQ-013: Port err output WIDTH-independent 1, registered error flag qualified by out_valid.

Function
- REQ-014: States IDLE, DIV, DONE; in_ready SHALL equal (state==IDLE), combinationally.
- REQ-015: Request accepted on a rising edge where in_valid && in_ready; opcode, is_signed, value1, value2 captured then.
- REQ-016: Accepted NOTHING produces no output; state stays IDLE.
- REQ-017: Accepted ADD/SUB/MUL/XOR/AND/OR/NOT: result registered on the accepting edge, state->DONE; out_valid high the following cycle (latency 1).
- REQ-018: ADD/SUB/MUL return the low WIDTH bits, wrap-around, no err; MUL identical for signed/unsigned; NOT = ~value1.
- REQ-019: Illegal opcode: result=0, err=1, latency 1.
- REQ-020: DIV/REM with nonzero divisor: state->DIV, restoring divider one quotient bit per cycle for exactly WIDTH cycles, then DONE; out_valid first high WIDTH+1 cycles after acceptance.
- REQ-021: Signed DIV/REM: operate on magnitudes; quotient negative iff operand signs differ; remainder takes dividend sign; quotient truncates toward zero.
- REQ-022: Divisor zero: no iteration, latency 1, err=1; DIV result all-ones, REM result = value1.
- REQ-023: Signed overflow (value1 = most negative, value2 = -1): DIV result = value1, REM result = 0, err=0, normal WIDTH+1 latency.
- REQ-024: DONE holds out_valid, result, err stable until out_ready; on out_valid && out_ready edge state->IDLE, out_valid->0.
- REQ-025: No new request is accepted in the cycle the result is consumed (in_ready rises the cycle after).
- REQ-026: Operand inputs SHALL not be sampled after the accepting edge.

Reset
- REQ-027: reset_n low forces state IDLE, out_valid=0, result=0, err=0, divider counter and working registers 0, immediately and independent of clk.
- REQ-028: Reset during DIV or DONE discards the operation; no out_valid for it after release.
- REQ-029: First request accepted on the first rising edge after reset_n deasserts with in_valid high.

Configuration
- REQ-030: Macro ALU_MC_DIV_EN: defined -> divider built, DIV/REM per REQ-020..023.
- REQ-031: ALU_MC_DIV_EN undefined -> no divider hardware, no DIV state; DIV/REM treated as illegal opcodes per REQ-019.

Verification (WIDTH=64, ALU_MC_DIV_EN defined unless stated)
- REQ-032: ADD 0xFFFF_FFFF_FFFF_FFFF + 2 -> out_valid next cycle, result 1, err 0.
- REQ-033: Unsigned DIV 100/7 -> out_valid exactly 65 cycles after acceptance, result 14; REM same operands -> 2; in_ready low throughout.
- REQ-034: Signed DIV -7/2 -> result -3 (0xFFFF_FFFF_FFFF_FFFD); signed REM -7/2 -> -1; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, err 0.
- REQ-035: DIV 5/0 -> latency 1, result all-ones, err 1; REM 5/0 -> result 5, err 1; opcode 12 -> result 0, err 1.
- REQ-036: MUL 3*5 with out_ready held low 10 cycles -> result 15 stable, out_valid high, in_ready low until out_ready; then in_ready high one cycle later.
- REQ-037: reset_n pulsed low 20 cycles into a DIV -> out_valid 0, result 0 immediately, no stale result after release; build without ALU_MC_DIV_EN: DIV 100/7 -> latency 1, result 0, err 1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; optional restoring divider for DIV/REM.
// Define ALU_MC_DIV_EN to build the divider; otherwise DIV/REM report as illegal opcodes.
module alu_mc #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_REM = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;

`ifdef ALU_MC_DIV_EN
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd2
    } state_t;
`endif

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

`ifdef ALU_MC_DIV_EN
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic             neg1, neg2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] rem_nx, quo_nx;
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;

    // Next-state, result and divider datapath
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        err_d       = err_q;
`ifdef ALU_MC_DIV_EN
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        // Signed operands are divided as magnitudes; the most negative value maps to itself,
        // which is still the correct unsigned magnitude.
        neg1 = is_signed & value1[WIDTH-1];
        neg2 = is_signed & value2[WIDTH-1];
        mag1 = neg1 ? -value1 : value1;
        mag2 = neg2 ? -value2 : value2;

        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_nx = trial[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = shifted[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        end
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    err_d       = 1'b0;
                    case (opcode)
                        OP_NOP: begin
                            state_d     = ST_IDLE;
                            out_valid_d = out_valid_q;
                            err_d       = err_q;
                        end
                        OP_ADD: result_d = value1 + value2;
                        OP_SUB: result_d = value1 - value2;
                        OP_MUL: result_d = value1 * value2;
                        OP_XOR: result_d = value1 ^ value2;
                        OP_AND: result_d = value1 & value2;
                        OP_OR:  result_d = value1 | value2;
                        OP_NOT: result_d = ~value1;
                        OP_DIV, OP_REM: begin
`ifdef ALU_MC_DIV_EN
                            if (value2 == '0) begin
                                result_d = (opcode == OP_DIV) ? '1 : value1;
                                err_d    = 1'b1;
                            end else begin
                                state_d     = ST_DIV;
                                out_valid_d = 1'b0;
                                rem_d       = '0;
                                quo_d       = mag1;
                                dvs_d       = mag2;
                                cnt_d       = '0;
                                is_rem_d    = (opcode == OP_REM);
                                neg_quo_d   = neg1 ^ neg2;
                                neg_rem_d   = neg1;
                            end
`else
                            result_d = '0;
                            err_d    = 1'b1;
`endif
                        end
                        default: begin
                            result_d = '0;
                            err_d    = 1'b1;
                        end
                    endcase
                end
            end
`ifdef ALU_MC_DIV_EN
            ST_DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    err_d       = 1'b0;
                    if (is_rem_q) result_d = neg_rem_q ? -rem_nx : rem_nx;
                    else          result_d = neg_quo_q ? -quo_nx : quo_nx;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
`ifdef ALU_MC_DIV_EN
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            err_q       <= err_d;
`ifdef ALU_MC_DIV_EN
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

endmodule
